uc_movimento_elevador: RTL and testbench
========================================

# uc_movimento_elevador

Control unit that consumes the request queue built by the new-request insertion FSM and drives the elevator car. It reads the head entry of the queue, moves the car one floor at a time toward that target, holds the door open on arrival, then pops the entry. The pop is interlocked with the insertion FSM so the queue is never shifted while an insertion is in progress. The head is re-read after every floor step, so a ride-along stop inserted ahead of the current target is honoured on the way.

## Interface
- N_ANDARES, 4: number of floors, valid floors 0..N_ANDARES-1
- ANDAR_W, 2: floor field width
- T_ANDAR, 50: clock cycles of travel per floor, ≥1
- T_PORTA, 100: clock cycles the door stays open, ≥1

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- iniciar  in  1  enables leaving idle
- fila_vazia  in  1  queue head address holds no valid entry
- andar_alvo  in  ANDAR_W  floor stored at queue head (synchronous RAM read data)
- insercao_ativa  in  1  high while the insertion FSM is not in its wait state
- pop  out  1  one-cycle pulse; queue shifts by one at the following edge
- andar_atual  out  ANDAR_W  current car floor
- subindo  out  1  motor up
- descendo  out  1  motor down
- porta_aberta  out  1  door open
- estado_db  out  4  current state encoding

## Operation
- States (encoding): OCIOSO 0, LE_FILA 1, DECIDE 2, MOVE 3, PASSO 4, PORTA 5, ESPERA_POP 6, REMOVE 7. Unused encodings → OCIOSO.
- OCIOSO: if iniciar && !fila_vazia → LE_FILA; else stay.
- LE_FILA: latch andar_alvo into internal alvo, clear timer → DECIDE.
- DECIDE:
  - alvo ≥ N_ANDARES (invalid) → ESPERA_POP, with no door cycle.
  - alvo == andar_atual → PORTA.
  - alvo > andar_atual → MOVE with dir = up.
  - Otherwise → MOVE with dir = down.
  - Timer is cleared on every exit.
- MOVE: subindo = dir up, descendo = dir down, timer increments; at timer == T_ANDAR-1 → PASSO.
- PASSO: andar_atual ± 1 per dir → LE_FILA (head is re-read).
- PORTA: porta_aberta = 1, timer increments; at timer == T_PORTA-1 → ESPERA_POP.
- ESPERA_POP: stay while insercao_ativa; else → REMOVE.
- REMOVE: pop = 1 → OCIOSO.
- Outputs are Moore, decoded from state only. subindo and descendo are never both 1.
- andar_atual saturates: it never increments past N_ANDARES-1 or decrements below 0. A saturating PASSO leaves it unchanged.
- Timer width is $clog2(max(T_ANDAR, T_PORTA)+1) and counts only in MOVE and PORTA.
- iniciar gates only the OCIOSO exit. Dropping it mid-trip does not abort the trip.
- fila_vazia is sampled only in OCIOSO.

## Timing
- Reset values: state OCIOSO, andar_atual 0, alvo 0, timer 0, dir up. Outputs: pop 0, subindo 0, descendo 0, porta_aberta 0, estado_db 0.
- Reset mid-operation returns to these values immediately (asynchronous) and the car floor is forced to 0. No pop is issued.
- Target already at the current floor: OCIOSO → LE_FILA → DECIDE → T_PORTA cycles of PORTA → ESPERA_POP → REMOVE. With insercao_ativa low, pop occurs T_PORTA+4 cycles after leaving OCIOSO.
- Each floor step costs T_ANDAR+3 cycles: LE_FILA, DECIDE, T_ANDAR cycles of MOVE, PASSO.
- A head change seen in LE_FILA after a PASSO retargets immediately. This can reverse direction.
- pop is exactly one cycle wide and never asserted while insercao_ativa = 1 in the same cycle.
- If insercao_ativa and the ESPERA_POP exit coincide, insertion wins: stay in ESPERA_POP.

## Test plan
- Use N_ANDARES = 4, T_ANDAR = 4, T_PORTA = 3 for all scenarios.
- Reset, fila_vazia = 1, iniciar = 1 for 20 cycles → remains OCIOSO, all outputs 0, andar_atual 0.
- Head 0 at floor 0, insercao_ativa 0 → porta_aberta high 3 cycles, pop pulse at cycle 7 after leaving OCIOSO, no motor output.
- Head 3 from floor 0 → subindo high 3×4 cycles total, andar_atual steps 1, 2, 3, then door 3 cycles, pop. Then head 1 → descendo, andar_atual 2, 1, door, pop.
- Head 3 from floor 0; after the first PASSO, head changes to 1 (ride-along) → car stops at floor 1, door opens, pop. Next head 3 resumes upward.
- insercao_ativa held high for 10 cycles during ESPERA_POP → pop delayed until the cycle after it falls, exactly one pulse.
- Assert reset during MOVE at floor 2 → immediate OCIOSO, andar_atual 0, subindo 0, no pop. An invalid head (ANDAR_W widened, value 5) → no door, pop after ESPERA_POP.

Source files
------------

// File: rtl/uc_movimento_elevador.sv
// uc_movimento_elevador: elevator car controller driven by the head of the request queue.
// Moves one floor per step, re-reads the head after every step, opens the door, then pops.
module uc_movimento_elevador #(
    parameter int N_ANDARES = 4,
    parameter int ANDAR_W   = 2,
    parameter int T_ANDAR   = 50,
    parameter int T_PORTA   = 100
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic               fila_vazia,
    input  logic [ANDAR_W-1:0] andar_alvo,
    input  logic               insercao_ativa,
    output logic               pop,
    output logic [ANDAR_W-1:0] andar_atual,
    output logic               subindo,
    output logic               descendo,
    output logic               porta_aberta,
    output logic [3:0]         estado_db
);
    localparam int T_MAX = (T_ANDAR > T_PORTA) ? T_ANDAR : T_PORTA;
    localparam int TW = $clog2(T_MAX + 1);
    localparam logic [ANDAR_W-1:0] TOPO = ANDAR_W'(N_ANDARES - 1);
    localparam logic [ANDAR_W:0] LIMITE = (ANDAR_W + 1)'(N_ANDARES);

    typedef enum logic [3:0] {
        OCIOSO     = 4'd0,
        LE_FILA    = 4'd1,
        DECIDE     = 4'd2,
        MOVE       = 4'd3,
        PASSO      = 4'd4,
        PORTA      = 4'd5,
        ESPERA_POP = 4'd6,
        REMOVE     = 4'd7
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [ANDAR_W-1:0] andar_q, andar_d, alvo_q, alvo_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               sobe_q, sobe_d;
    logic               invalido;

    assign invalido = {1'b0, alvo_q} >= LIMITE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            andar_q  <= '0;
            alvo_q   <= '0;
            timer_q  <= '0;
            sobe_q   <= 1'b1;
        end else begin
            estado_q <= estado_d;
            andar_q  <= andar_d;
            alvo_q   <= alvo_d;
            timer_q  <= timer_d;
            sobe_q   <= sobe_d;
        end
    end

    always_comb begin
        estado_d = OCIOSO;
        andar_d  = andar_q;
        alvo_d   = alvo_q;
        sobe_d   = sobe_q;
        timer_d  = (estado_q == MOVE || estado_q == PORTA) ? timer_q + 1'b1 : '0;
        case (estado_q)
            OCIOSO:     estado_d = (iniciar && !fila_vazia) ? LE_FILA : OCIOSO;
            LE_FILA: begin
                alvo_d   = andar_alvo;
                estado_d = DECIDE;
            end
            DECIDE: begin
                estado_d = invalido ? ESPERA_POP : (alvo_q == andar_q) ? PORTA : MOVE;
                sobe_d   = (!invalido && alvo_q != andar_q) ? (alvo_q > andar_q) : sobe_q;
            end
            MOVE:       estado_d = (timer_q == TW'(T_ANDAR - 1)) ? PASSO : MOVE;
            PASSO: begin
                // Saturate at the shaft ends so a stray step never wraps the floor.
                andar_d  = sobe_q ? ((andar_q == TOPO) ? andar_q : andar_q + 1'b1)
                                  : ((andar_q == '0) ? andar_q : andar_q - 1'b1);
                estado_d = LE_FILA;
            end
            PORTA:      estado_d = (timer_q == TW'(T_PORTA - 1)) ? ESPERA_POP : PORTA;
            ESPERA_POP: estado_d = insercao_ativa ? ESPERA_POP : REMOVE;
            REMOVE:     estado_d = OCIOSO;
            default:    estado_d = OCIOSO;
        endcase
    end

    assign pop          = estado_q == REMOVE;
    assign subindo      = estado_q == MOVE && sobe_q;
    assign descendo     = estado_q == MOVE && !sobe_q;
    assign porta_aberta = estado_q == PORTA;
    assign andar_atual  = andar_q;
    assign estado_db    = estado_q;
endmodule

// File: tb/tb_uc_movimento_elevador.sv
// tb_uc_movimento_elevador: directed bench for the elevator movement controller.
module tb_uc_movimento_elevador;
    logic       clock, reset, iniciar, fila_vazia, insercao_ativa;
    logic [2:0] andar_alvo, andar_atual;
    logic       pop, subindo, descendo, porta_aberta;
    logic [3:0] estado_db;
    int checks = 0;
    int errors = 0;
    int pop_at, n_porta, n_sub, n_desc, n_both, floors;

    uc_movimento_elevador #(.N_ANDARES(4), .ANDAR_W(3), .T_ANDAR(4), .T_PORTA(3)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fila_vazia(fila_vazia),
        .andar_alvo(andar_alvo), .insercao_ativa(insercao_ativa), .pop(pop),
        .andar_atual(andar_atual), .subindo(subindo), .descendo(descendo),
        .porta_aberta(porta_aberta), .estado_db(estado_db)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Runs from OCIOSO until the pop pulse, then one more cycle back in OCIOSO.
    task automatic trip(input int budget, output int p_at, output int np, output int ns,
                        output int nd, output int nb, output int fl);
        logic [2:0] prev;
        p_at = -1; np = 0; ns = 0; nd = 0; nb = 0; fl = 0;
        prev = andar_atual;
        for (int c = 1; c <= budget; c++) begin
            step();
            np += int'(porta_aberta);
            ns += int'(subindo);
            nd += int'(descendo);
            nb += int'(subindo && descendo);
            if (andar_atual !== prev) begin
                fl = fl * 10 + int'(andar_atual);
                prev = andar_atual;
            end
            if (pop === 1'b1) begin
                p_at = c;
                fila_vazia = 1'b1;
                break;
            end
        end
        step();
        chk("idle_after_pop", estado_db, 0);
        chk("pop_one_cycle", pop, 0);
    endtask

    initial begin
        reset = 1'b1; iniciar = 1'b0; fila_vazia = 1'b1; insercao_ativa = 1'b0; andar_alvo = 3'd0;
        step(); step();
        reset = 1'b0;
        chk("rst_state", estado_db, 0);
        chk("rst_floor", andar_atual, 0);
        chk("rst_outs", {pop, subindo, descendo, porta_aberta}, 0);

        iniciar = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("empty_idle", {estado_db, pop, subindo, descendo, porta_aberta, andar_atual}, 0);
        end

        // Head at the current floor: door only.
        andar_alvo = 3'd0; fila_vazia = 1'b0;
        trip(40, pop_at, n_porta, n_sub, n_desc, n_both, floors);
        chk("same_pop_at", pop_at, 7);
        chk("same_door", n_porta, 3);
        chk("same_motor", n_sub + n_desc, 0);
        chk("same_floor", andar_atual, 0);

        // Up 0 -> 3.
        andar_alvo = 3'd3; fila_vazia = 1'b0;
        trip(80, pop_at, n_porta, n_sub, n_desc, n_both, floors);
        chk("up_pop_at", pop_at, 28);
        chk("up_sub", n_sub, 12);
        chk("up_desc", n_desc, 0);
        chk("up_door", n_porta, 3);
        chk("up_floors", floors, 123);

        // Down 3 -> 1.
        andar_alvo = 3'd1; fila_vazia = 1'b0;
        trip(80, pop_at, n_porta, n_sub, n_desc, n_both, floors);
        chk("dn_pop_at", pop_at, 21);
        chk("dn_desc", n_desc, 8);
        chk("dn_sub", n_sub, 0);
        chk("dn_door", n_porta, 3);
        chk("dn_floors", floors, 21);
        chk("dn_both", n_both, 0);

        // Ride-along: head 3 from floor 0, head becomes 1 after the first step.
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst2_floor", andar_atual, 0);
        andar_alvo = 3'd3; fila_vazia = 1'b0;
        step(); step(); step();
        chk("ride_moving_up", {estado_db, subindo, descendo}, {4'd3, 2'b10});
        step(); step(); step(); step();
        chk("ride_passo", estado_db, 4);
        andar_alvo = 3'd1;
        trip(40, pop_at, n_porta, n_sub, n_desc, n_both, floors);
        chk("ride_pop_at", pop_at, 7);
        chk("ride_no_motor", n_sub + n_desc, 0);
        chk("ride_door", n_porta, 3);
        chk("ride_floor", andar_atual, 1);
        andar_alvo = 3'd3; fila_vazia = 1'b0;
        trip(80, pop_at, n_porta, n_sub, n_desc, n_both, floors);
        chk("resume_pop_at", pop_at, 21);
        chk("resume_sub", n_sub, 8);
        chk("resume_floors", floors, 23);

        // Insertion interlock holds ESPERA_POP.
        andar_alvo = 3'd3; fila_vazia = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("ins_wait_state", estado_db, 6);
        insercao_ativa = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ins_hold", {estado_db, pop}, {4'd6, 1'b0});
        end
        insercao_ativa = 1'b0;
        fila_vazia = 1'b1;
        step();
        chk("ins_pop", {estado_db, pop}, {4'd7, 1'b1});
        step();
        chk("ins_pop_once", {estado_db, pop}, {4'd0, 1'b0});

        // Asynchronous reset in MOVE at floor 2 (descending from 3 toward 0).
        andar_alvo = 3'd0; fila_vazia = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("rstmv_state", {estado_db, descendo, andar_atual}, {4'd3, 1'b1, 3'd2});
        #2 reset = 1'b1;
        #1;
        chk("rstmv_async", {estado_db, andar_atual, subindo, descendo, pop}, 0);
        fila_vazia = 1'b1;
        step();
        chk("rstmv_no_pop", pop, 0);
        reset = 1'b0;
        step();
        chk("rstmv_idle", {estado_db, andar_atual}, 0);

        // Invalid head skips the door.
        andar_alvo = 3'd5; fila_vazia = 1'b0;
        trip(40, pop_at, n_porta, n_sub, n_desc, n_both, floors);
        chk("inv_pop_at", pop_at, 4);
        chk("inv_no_door", n_porta, 0);
        chk("inv_no_motor", n_sub + n_desc, 0);
        chk("inv_floor", andar_atual, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
